// File: rtl/layer_serializer_if.sv
// ============================================================================
// Module  : layer_serializer_if
// Brief   : Layer-to-layer bus bundle: parallel result side and serial side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface layer_serializer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATAWIDTH   = 16
);
    logic [DATAWIDTH*NUM_NEURONS-1:0] x_in;
    logic [NUM_NEURONS-1:0]           i_valid;
    logic [DATAWIDTH-1:0]             out_val;
    logic                             out_valid;
    logic                             busy;
    logic                             overrun;

    modport master (
        output x_in,
        output i_valid,
        input  out_val,
        input  out_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  x_in,
        input  i_valid,
        output out_val,
        output out_valid,
        output busy,
        output overrun
    );
endinterface

`default_nettype wire

// File: rtl/layer_serializer.sv
// ============================================================================
// Module  : layer_serializer
// Brief   : Captures a full layer result frame and replays it one word/cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATAWIDTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    layer_serializer_if.slave bus
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATAWIDTH-1:0] frame_q [NUM_NEURONS];
    logic [DATAWIDTH-1:0] frame_d [NUM_NEURONS];
    logic [DATAWIDTH-1:0] out_val_q, out_val_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic                 cap;
    logic                 at_last;
    logic                 accept;
    logic [IDX_W-1:0]     idx_inc;

    assign cap     = &bus.i_valid;
    assign at_last = (idx_q == LAST_IDX);
    // A new frame is taken when idle, or on the cycle the last word is on the wire.
    assign accept  = cap && ((state_q == S_IDLE) || at_last);
    assign idx_inc = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_val_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                frame_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_val_q   <= out_val_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                frame_q[k] <= frame_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cap) state_d = S_SEND;
            S_SEND:  if (at_last && !cap) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // idx_q tracks the word currently presented on out_val while in SEND.
    always_comb begin
        idx_d       = idx_q;
        out_val_d   = out_val_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        overrun_d   = 1'b0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            frame_d[k] = frame_q[k];
        end

        if (accept) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                frame_d[k] = bus.x_in[k*DATAWIDTH +: DATAWIDTH];
            end
            out_val_d   = bus.x_in[DATAWIDTH-1:0];
            idx_d       = '0;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
        end else if (state_q == S_SEND && !at_last) begin
            idx_d       = idx_inc;
            out_val_d   = frame_q[idx_inc];
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            overrun_d   = cap;
        end else if (state_q == S_SEND) begin
            idx_d = '0;
        end
    end

    assign bus.out_val   = out_val_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

`default_nettype wire
